// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state encoding, data-width codes and parity helper for uart_tx_cfg
// Revision : 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam logic [1:0] DBITS_5 = 2'b00;
   localparam logic [1:0] DBITS_6 = 2'b01;
   localparam logic [1:0] DBITS_7 = 2'b10;
   localparam logic [1:0] DBITS_8 = 2'b11;

   function automatic logic [3:0] dbits_to_n(input logic [1:0] code);
      logic [3:0] n;
      case (code)
         DBITS_5: n = 4'd5;
         DBITS_6: n = 4'd6;
         DBITS_7: n = 4'd7;
         DBITS_8: n = 4'd8;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // Even parity over the low nbits of data; seeding with odd gives odd parity.
   function automatic logic calc_parity(input logic [7:0] data,
                                        input logic [3:0] nbits,
                                        input logic       odd);
      logic p;
      p = odd;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < nbits) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// uart_tx_cfg : runtime-configurable UART transmitter (5-8 data bits, 1/2 stop)
//               parity stage built only when UART_TX_PARITY_EN is defined
// Revision    : 1.0
// ============================================================================
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int OVS = 16,
   parameter int DW  = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [1:0]    cfg_dbits,
   input  logic          cfg_stop2,
   input  logic          cfg_par_en,
   input  logic          cfg_par_odd,
   output logic          tx,
   output logic          tx_busy,
   output logic          tx_done
);

   localparam int            CW        = (OVS > 1) ? $clog2(OVS) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(OVS - 1);

   uart_state_t   state_q, state_d;
   logic [CW-1:0] tcnt_q, tcnt_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [1:0]    dbits_q, dbits_d;
   logic          stop2_q, stop2_d;
   logic          par_en_q, par_en_d;
   logic          par_bit_q, par_bit_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [7:0]    data8;
   logic          bit_end;
   logic [2:0]    last_dbit;

   generate
      if (DW >= 8) begin : g_data_wide
         assign data8 = in_data[7:0];
         if (DW > 8) begin : g_data_extra
            logic unused_hi;
            assign unused_hi = ^in_data[DW-1:8];
         end
      end else begin : g_data_narrow
         assign data8 = {{(8-DW){1'b0}}, in_data};
      end
   endgenerate

`ifndef UART_TX_PARITY_EN
   logic unused_par;
   assign unused_par = cfg_par_en ^ cfg_par_odd;
`endif

   assign bit_end   = tick && (tcnt_q == TICK_LAST);
   assign last_dbit = 3'(dbits_to_n(dbits_q) - 4'd1);

   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      bcnt_d    = bcnt_q;
      shift_d   = shift_q;
      dbits_d   = dbits_q;
      stop2_d   = stop2_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      tx_d      = tx_q;
      done_d    = 1'b0;

      if (state_q != ST_IDLE && tick) begin
         tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (in_valid) begin
               state_d = ST_START;
               tx_d    = 1'b0;
               tcnt_d  = '0;
               bcnt_d  = '0;
               shift_d = data8;
               dbits_d = cfg_dbits;
               stop2_d = cfg_stop2;
`ifdef UART_TX_PARITY_EN
               par_en_d  = cfg_par_en;
               par_bit_d = calc_parity(data8, dbits_to_n(cfg_dbits), cfg_par_odd);
`else
               par_en_d  = 1'b0;
               par_bit_d = 1'b0;
`endif
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bcnt_q == last_dbit) begin
                  bcnt_d = '0;
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bcnt_d  = bcnt_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
               bcnt_d  = '0;
            end
         end
         ST_STOP: begin
            // bcnt doubles as the stop-bit index for two-stop frames
            if (bit_end) begin
               if (stop2_q && bcnt_q == 3'd0) begin
                  bcnt_d = 3'd1;
               end else begin
                  state_d = ST_IDLE;
                  bcnt_d  = '0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tcnt_q    <= '0;
         bcnt_q    <= '0;
         shift_q   <= '0;
         dbits_q   <= '0;
         stop2_q   <= 1'b0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         bcnt_q    <= bcnt_d;
         shift_q   <= shift_d;
         dbits_q   <= dbits_d;
         stop2_q   <= stop2_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign tx       = tx_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule
`default_nettype wire
